// File: rtl/rom_read_arbiter_if.sv
// Bus bundle between the ROM read clients, the SDRAM ROM read port and the ROM loader.
interface rom_read_arbiter_if #(
  parameter int unsigned AW = 23
);
  logic [2:0]    c_req;
  logic [2:0]    c_ack;
  logic [AW-1:0] c0_a;
  logic [AW-1:0] c1_a;
  logic [AW-1:0] c2_a;
  logic [15:0]   c0_q;
  logic [15:0]   c1_q;
  logic [15:0]   c2_q;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_a;
  logic [15:0]   mem_q;
  logic          inv_stb;
  logic [AW-1:0] inv_a;
  logic          flush;

  // Arbiter side
  modport slave (
    input  c_req, c0_a, c1_a, c2_a, mem_ack, mem_q, inv_stb, inv_a, flush,
    output c_ack, c0_q, c1_q, c2_q, mem_req, mem_a
  );

  // Clients / SDRAM / loader side
  modport master (
    output c_req, c0_a, c1_a, c2_a, mem_ack, mem_q, inv_stb, inv_a, flush,
    input  c_ack, c0_q, c1_q, c2_q, mem_req, mem_a
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing the SDRAM ROM read port between three toggle-handshake
// clients, with a one-word hit buffer kept coherent with ROM writes and flushes.
module rom_read_arbiter #(
  parameter int unsigned AW     = 23,
  parameter bit          HIT_EN = 1'b1
) (
  input logic             clk,
  input logic             reset_n,
  rom_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHit, StWait} state_e;

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          last_q, last_d;
  logic [2:0]          c_ack_q, c_ack_d;
  logic [2:0][15:0]    cq_q, cq_d;
  logic                mem_req_q, mem_req_d;
  logic [AW-1:0]       mem_a_q, mem_a_d;
  logic                buf_valid_q, buf_valid_d;
  logic [AW-1:0]       buf_a_q, buf_a_d;
  logic [15:0]         buf_d_q, buf_d_d;
  logic                poison_q, poison_d;

  logic [2:0]          pend;
  logic [2:0][AW-1:0]  c_addr;
  logic                gnt_vld;
  logic [1:0]          gnt;
  logic [AW-1:0]       gnt_addr;
  logic                inv_buf;
  logic                inv_mem;
  logic                hit;

  assign pend      = bus.c_req ^ c_ack_q;
  assign c_addr[0] = bus.c0_a;
  assign c_addr[1] = bus.c1_a;
  assign c_addr[2] = bus.c2_a;
  assign gnt_addr  = c_addr[gnt];
  assign inv_buf   = bus.inv_stb && (bus.inv_a == buf_a_q);
  assign inv_mem   = bus.inv_stb && (bus.inv_a == mem_a_q);
  assign hit       = HIT_EN && buf_valid_q && !bus.flush && (gnt_addr == buf_a_q) && !inv_buf;

  // Round-robin pick: first pending client after last; scanning downward lets the
  // nearest successor overwrite farther ones.
  always_comb begin
    int s;
    gnt_vld = 1'b0;
    gnt     = last_q;
    for (int k = 3; k >= 1; k--) begin
      s = int'(last_q) + k;
      if (s >= 3) s = s - 3;
      if (pend[s]) begin
        gnt_vld = 1'b1;
        gnt     = 2'(s);
      end
    end
  end

  // Next-state: FSM, client handshakes, SDRAM request and hit-buffer coherency.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    c_ack_d     = c_ack_q;
    cq_d        = cq_q;
    mem_req_d   = mem_req_q;
    mem_a_d     = mem_a_q;
    buf_valid_d = buf_valid_q;
    buf_a_d     = buf_a_q;
    buf_d_d     = buf_d_q;
    poison_d    = poison_q;

    if (bus.flush || inv_buf) buf_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          sel_d  = gnt;
          last_d = gnt;
          if (hit) begin
            state_d = StHit;
          end else begin
            mem_a_d   = gnt_addr;
            mem_req_d = ~mem_req_q;
            poison_d  = 1'b0;
            state_d   = StWait;
          end
        end
      end
      StHit: begin
        cq_d[sel_q]    = buf_d_q;
        c_ack_d[sel_q] = bus.c_req[sel_q];
        state_d        = StIdle;
      end
      StWait: begin
        poison_d = poison_q | inv_mem;
        if (bus.mem_ack == mem_req_q) begin
          cq_d[sel_q]    = bus.mem_q;
          c_ack_d[sel_q] = bus.c_req[sel_q];
          buf_a_d        = mem_a_q;
          buf_d_d        = bus.mem_q;
          // A write to this word while in flight makes the returned data stale for caching.
          buf_valid_d    = !(poison_q || inv_mem || bus.flush);
          poison_d       = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sel_q       <= 2'd0;
      last_q      <= 2'd2;
      c_ack_q     <= 3'b000;
      cq_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_a_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_a_q     <= '0;
      buf_d_q     <= 16'h0000;
      poison_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      c_ack_q     <= c_ack_d;
      cq_q        <= cq_d;
      mem_req_q   <= mem_req_d;
      mem_a_q     <= mem_a_d;
      buf_valid_q <= buf_valid_d;
      buf_a_q     <= buf_a_d;
      buf_d_q     <= buf_d_d;
      poison_q    <= poison_d;
    end
  end

  assign bus.c_ack   = c_ack_q;
  assign bus.c0_q    = cq_q[0];
  assign bus.c1_q    = cq_q[1];
  assign bus.c2_q    = cq_q[2];
  assign bus.mem_req = mem_req_q;
  assign bus.mem_a   = mem_a_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: one DUT with the hit buffer, one without.
module tb_rom_read_arbiter;
  localparam int unsigned AW  = 23;
  localparam int          LAT = 3;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] word100 = 16'hBEEF;

  rom_read_arbiter_if #(.AW(AW)) if0 ();
  rom_read_arbiter_if #(.AW(AW)) if1 ();

  rom_read_arbiter #(.AW(AW), .HIT_EN(1'b1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  rom_read_arbiter #(.AW(AW), .HIT_EN(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] data_for(input logic [AW-1:0] a);
    if (a == 23'h000100) return word100;
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // SDRAM models: answer LAT clocks after seeing a request toggle.
  int cnt0 = 0;
  int cnt1 = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if0.mem_ack <= 1'b0;
      cnt0        <= 0;
    end else if (if0.mem_req != if0.mem_ack) begin
      if (cnt0 == LAT - 1) begin
        if0.mem_ack <= if0.mem_req;
        if0.mem_q   <= data_for(if0.mem_a);
        cnt0        <= 0;
      end else cnt0 <= cnt0 + 1;
    end
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if1.mem_ack <= 1'b0;
      cnt1        <= 0;
    end else if (if1.mem_req != if1.mem_ack) begin
      if (cnt1 == LAT - 1) begin
        if1.mem_ack <= if1.mem_req;
        if1.mem_q   <= data_for(if1.mem_a);
        cnt1        <= 0;
      end else cnt1 <= cnt1 + 1;
    end
  end

  // Request-toggle monitors: count toggles and log the issued address.
  int          tog0 = 0;
  int          tog1 = 0;
  logic        prev0, prev1;
  logic [AW-1:0] alog [64];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev0 <= 1'b0;
    else begin
      prev0 <= if0.mem_req;
      if (if0.mem_req != prev0) begin
        alog[tog0 % 64] <= if0.mem_a;
        tog0            <= tog0 + 1;
      end
    end
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev1 <= 1'b0;
    else begin
      prev1 <= if1.mem_req;
      if (if1.mem_req != prev1) tog1 <= tog1 + 1;
    end
  end

  // One read on dut0; optionally pulse inv_stb at the same address after inv_at clocks.
  task automatic do_read(input int cl, input logic [AW-1:0] a, input int inv_at,
                         output int cyc, output logic [15:0] d);
    bit done;
    done = 1'b0;
    cyc  = 0;
    @(negedge clk);
    case (cl)
      0: if0.c0_a = a;
      1: if0.c1_a = a;
      default: if0.c2_a = a;
    endcase
    if0.c_req[cl] = ~if0.c_req[cl];
    for (int n = 1; n <= 60 && !done; n++) begin
      @(posedge clk);
      #1;
      if0.inv_stb = 1'b0;
      if (if0.c_ack[cl] == if0.c_req[cl]) begin
        done = 1'b1;
        cyc  = n;
      end else if (n == inv_at) begin
        if0.inv_a   = a;
        if0.inv_stb = 1'b1;
      end
    end
    if0.inv_stb = 1'b0;
    case (cl)
      0: d = if0.c0_q;
      1: d = if0.c1_q;
      default: d = if0.c2_q;
    endcase
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL read_timeout client=%0d addr=%h: no ack within 60 clocks", cl, a);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    if0.c_req = 3'b000; if0.c0_a = '0; if0.c1_a = '0; if0.c2_a = '0;
    if0.inv_stb = 1'b0; if0.inv_a = '0; if0.flush = 1'b0;
    if1.c_req = 3'b000; if1.c0_a = '0; if1.c1_a = '0; if1.c2_a = '0;
    if1.inv_stb = 1'b0; if1.inv_a = '0; if1.flush = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if0.c_ack !== 3'b000 || if0.mem_req !== 1'b0 || if0.mem_a !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl ack=%b mem_req=%b mem_a=%h, want 000 0 0",
               if0.c_ack, if0.mem_req, if0.mem_a);
    end
    n_checks++;
    if (if0.c0_q !== 16'h0 || if0.c1_q !== 16'h0 || if0.c2_q !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data q=%h %h %h, want 0", if0.c0_q, if0.c1_q, if0.c2_q);
    end
  endtask

  task automatic test_miss;
    int cyc, t;
    logic [15:0] d;
    t = tog0;
    do_read(0, 23'h000100, 0, cyc, d);
    n_checks++;
    if (d !== 16'hBEEF) begin n_fail++; $display("FAIL miss_data got %h want BEEF", d); end
    n_checks++;
    if (cyc !== LAT + 2) begin
      n_fail++; $display("FAIL miss_latency got %0d want %0d", cyc, LAT + 2);
    end
    n_checks++;
    if (tog0 - t !== 1 || alog[t % 64] !== 23'h000100) begin
      n_fail++;
      $display("FAIL miss_memreq toggles=%0d addr=%h want 1 000100", tog0 - t, alog[t % 64]);
    end
  endtask

  task automatic test_hit;
    int cyc, t;
    logic [15:0] d;
    t = tog0;
    do_read(0, 23'h000100, 0, cyc, d);
    n_checks++;
    if (d !== 16'hBEEF || cyc !== 2) begin
      n_fail++; $display("FAIL hit data=%h cyc=%0d want BEEF 2", d, cyc);
    end
    n_checks++;
    if (tog0 !== t) begin n_fail++; $display("FAIL hit_nomem toggles=%0d want 0", tog0 - t); end
    n_checks++;
    if (if0.c1_q !== 16'h0 || if0.c2_q !== 16'h0) begin
      n_fail++; $display("FAIL hit_others c1=%h c2=%h want 0 0", if0.c1_q, if0.c2_q);
    end
  endtask

  task automatic test_invalidate;
    int cyc, t;
    logic [15:0] d;
    @(negedge clk);
    if0.inv_a   = 23'h000100;
    if0.inv_stb = 1'b1;
    word100     = 16'h1234;
    @(negedge clk);
    if0.inv_stb = 1'b0;
    t = tog0;
    do_read(0, 23'h000100, 0, cyc, d);
    n_checks++;
    if (tog0 - t !== 1 || d !== 16'h1234) begin
      n_fail++; $display("FAIL invalidate toggles=%0d data=%h want 1 1234", tog0 - t, d);
    end
  endtask

  task automatic test_poison;
    int cyc, t;
    logic [15:0] d;
    t = tog0;
    do_read(1, 23'h000040, 2, cyc, d);
    n_checks++;
    if (d !== 16'hA5E5) begin n_fail++; $display("FAIL poison_data got %h want A5E5", d); end
    n_checks++;
    if (dut0.buf_valid_q !== 1'b0) begin
      n_fail++; $display("FAIL poison_valid buf_valid=%b want 0", dut0.buf_valid_q);
    end
    do_read(1, 23'h000040, 0, cyc, d);
    n_checks++;
    if (tog0 - t !== 2 || d !== 16'hA5E5) begin
      n_fail++; $display("FAIL poison_reread toggles=%0d data=%h want 2 A5E5", tog0 - t, d);
    end
  endtask

  task automatic run_round(input string name, input logic [AW-1:0] a0, a1, a2,
                           input logic [AW-1:0] e0, e1, e2);
    int t;
    bit done;
    t    = tog0;
    done = 1'b0;
    @(negedge clk);
    if0.c0_a  = a0;
    if0.c1_a  = a1;
    if0.c2_a  = a2;
    if0.c_req = ~if0.c_req;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk);
      #1;
      if (if0.c_ack == if0.c_req) done = 1'b1;
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL %s_timeout ack=%b", name, if0.c_ack); end
    n_checks++;
    if (tog0 - t !== 3 || alog[t % 64] !== e0 || alog[(t + 1) % 64] !== e1 ||
        alog[(t + 2) % 64] !== e2) begin
      n_fail++;
      $display("FAIL %s_order toggles=%0d seq=%h %h %h want 3 %h %h %h", name, tog0 - t,
               alog[t % 64], alog[(t + 1) % 64], alog[(t + 2) % 64], e0, e1, e2);
    end
    n_checks++;
    if (if0.c0_q !== data_for(a0) || if0.c1_q !== data_for(a1) || if0.c2_q !== data_for(a2))
    begin
      n_fail++;
      $display("FAIL %s_data q=%h %h %h want %h %h %h", name, if0.c0_q, if0.c1_q, if0.c2_q,
               data_for(a0), data_for(a1), data_for(a2));
    end
  endtask

  task automatic test_round_robin;
    int cyc;
    logic [15:0] d;
    do_read(2, 23'h000040, 0, cyc, d);  // last = 2
    run_round("rr_first", 23'h10, 23'h20, 23'h30, 23'h10, 23'h20, 23'h30);
    run_round("rr_second", 23'h11, 23'h21, 23'h31, 23'h11, 23'h21, 23'h31);
    do_read(0, 23'h000050, 0, cyc, d);  // last = 0
    run_round("rr_last0", 23'h12, 23'h22, 23'h32, 23'h22, 23'h32, 23'h12);
  endtask

  task automatic test_flush;
    int cyc, t;
    logic [15:0] d, q0;
    q0 = if0.c0_q;
    if0.flush = 1'b1;
    t = tog0;
    do_read(2, 23'h000200, 0, cyc, d);
    do_read(2, 23'h000200, 0, cyc, d);
    if0.flush = 1'b0;
    n_checks++;
    if (tog0 - t !== 2 || d !== 16'hA7A5) begin
      n_fail++; $display("FAIL flush toggles=%0d data=%h want 2 A7A5", tog0 - t, d);
    end
    n_checks++;
    if (if0.c0_q !== q0) begin
      n_fail++; $display("FAIL flush_c0_stable c0_q=%h want %h", if0.c0_q, q0);
    end
  endtask

  task automatic test_hit_disable;
    int t;
    bit done;
    t = tog1;
    for (int r = 0; r < 2; r++) begin
      done = 1'b0;
      @(negedge clk);
      if1.c0_a     = 23'h000100;
      if1.c_req[0] = ~if1.c_req[0];
      for (int n = 0; n < 60 && !done; n++) begin
        @(posedge clk);
        #1;
        if (if1.c_ack[0] == if1.c_req[0]) done = 1'b1;
      end
      n_checks++;
      if (!done || if1.c0_q !== 16'h1234) begin
        n_fail++; $display("FAIL nohit_read%0d done=%b data=%h want 1 1234", r, done, if1.c0_q);
      end
    end
    n_checks++;
    if (tog1 - t !== 2) begin
      n_fail++; $display("FAIL nohit_toggles got %0d want 2", tog1 - t);
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    if0.c0_a     = 23'h000300;
    if0.c_req[0] = ~if0.c_req[0];
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (if0.c_ack !== 3'b000 || if0.mem_req !== 1'b0 || if0.mem_a !== '0 ||
        if0.c0_q !== 16'h0 || if0.c1_q !== 16'h0 || if0.c2_q !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_wait ack=%b mem_req=%b mem_a=%h q=%h %h %h, want all 0",
               if0.c_ack, if0.mem_req, if0.mem_a, if0.c0_q, if0.c1_q, if0.c2_q);
    end
    if0.c_req = 3'b000;
    if1.c_req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_miss;
    test_hit;
    test_invalidate;
    test_poison;
    test_round_robin;
    test_flush;
    test_hit_disable;
    test_reset_mid_wait;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
